// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle MIPS control unit.
// Sequences FETCH -> EXEC -> MEM/MULDIV -> commit, tracks the branch delay
// slot, times the multiply/divide unit and stops the core on a jump to 0.
module mips_cpu_control_fsm #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 33,
  parameter int CNT_WIDTH   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] instr_readdata,
  input  logic        instr_waitrequest,
  input  logic        data_waitrequest,
  input  logic [1:0]  addr_low,
  input  logic        is_true,
  input  logic        target_is_zero,
  output logic        active,
  output logic        instr_read,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  byte_enable,
  output logic [31:0] ir,
  output logic        pc_write_enable,
  output logic [1:0]  pc_sel,
  output logic        target_latch,
  output logic        reg_write_enable,
  output logic        muldiv_start,
  output logic        hi_lo_write
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MEM    = 3'd2,
    ST_MULDIV = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Counter reload values: the unit is done when the counter reaches zero.
  localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);

  state_t               state_r;
  logic [31:0]          ir_r;
  logic                 delay_pending_r;
  logic [CNT_WIDTH-1:0] cnt_r;

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       cls_load_s;
  logic       cls_store_s;
  logic       cls_muldiv_s;
  logic       cls_div_s;
  logic       cls_jump_s;
  logic       cls_branch_s;
  logic       exec_wr_s;
  logic [1:0] mem_size_s;
  logic       run_s;
  logic       commit_s;
  logic       wr_s;
  logic       take_s;
  logic       halt_s;

  // Byte lanes touched by an access of the given size at the given address.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << addr;
      SZ_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign opcode_s = ir_r[31:26];
  assign funct_s  = ir_r[5:0];
  assign ir       = ir_r;
  assign active   = (state_r != ST_HALTED);

  // Classify the latched instruction; unknown opcodes behave as I-type ALU.
  always_comb begin
    cls_load_s   = 1'b0;
    cls_store_s  = 1'b0;
    cls_muldiv_s = 1'b0;
    cls_div_s    = 1'b0;
    cls_jump_s   = 1'b0;
    cls_branch_s = 1'b0;
    exec_wr_s    = 1'b1;
    mem_size_s   = SZ_WORD;
    case (opcode_s)
      6'h00: begin
        case (funct_s)
          6'h08:        begin cls_jump_s = 1'b1; exec_wr_s = 1'b0; end
          6'h09:        cls_jump_s = 1'b1;
          6'h11, 6'h13: exec_wr_s = 1'b0;
          6'h18, 6'h19: begin cls_muldiv_s = 1'b1; exec_wr_s = 1'b0; end
          6'h1a, 6'h1b: begin cls_muldiv_s = 1'b1; cls_div_s = 1'b1; exec_wr_s = 1'b0; end
          default:      exec_wr_s = 1'b1;
        endcase
      end
      // REGIMM: rt[4] selects the linking BLTZAL/BGEZAL forms
      6'h01: begin cls_branch_s = 1'b1; exec_wr_s = ir_r[20] & is_true; end
      6'h02: begin cls_jump_s = 1'b1; exec_wr_s = 1'b0; end
      6'h03: cls_jump_s = 1'b1;
      6'h04, 6'h05, 6'h06, 6'h07: begin cls_branch_s = 1'b1; exec_wr_s = 1'b0; end
      6'h20, 6'h24:        begin cls_load_s = 1'b1; mem_size_s = SZ_BYTE; end
      6'h21, 6'h25:        begin cls_load_s = 1'b1; mem_size_s = SZ_HALF; end
      6'h22, 6'h23, 6'h26: begin cls_load_s = 1'b1; mem_size_s = SZ_WORD; end
      6'h28: begin cls_store_s = 1'b1; exec_wr_s = 1'b0; mem_size_s = SZ_BYTE; end
      6'h29: begin cls_store_s = 1'b1; exec_wr_s = 1'b0; mem_size_s = SZ_HALF; end
      6'h2b: begin cls_store_s = 1'b1; exec_wr_s = 1'b0; mem_size_s = SZ_WORD; end
      default: exec_wr_s = 1'b1;
    endcase
  end

  // Strobes follow the current state and this cycle's bus handshakes so a
  // released waitrequest commits in the same cycle; reset and freeze gate them.
  always_comb begin
    run_s        = clk_enable & reset;
    instr_read   = 1'b0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    byte_enable  = 4'b1111;
    muldiv_start = 1'b0;
    hi_lo_write  = 1'b0;
    commit_s     = 1'b0;
    wr_s         = 1'b0;
    take_s       = 1'b0;
    case (state_r)
      ST_FETCH: instr_read = run_s;
      ST_EXEC: begin
        if (cls_muldiv_s) begin
          muldiv_start = run_s;
        end else if (cls_load_s | cls_store_s) begin
          commit_s = 1'b0;
        end else begin
          commit_s = run_s;
          wr_s     = exec_wr_s;
          take_s   = cls_jump_s | (cls_branch_s & is_true);
        end
      end
      ST_MEM: begin
        data_read   = run_s & cls_load_s;
        data_write  = run_s & cls_store_s;
        byte_enable = lane_mask(mem_size_s, addr_low);
        if (!data_waitrequest) begin
          commit_s = run_s;
          wr_s     = cls_load_s;
        end else begin
          commit_s = 1'b0;
        end
      end
      ST_MULDIV: begin
        if (cnt_r == CNT_ZERO) begin
          commit_s    = run_s;
          hi_lo_write = run_s;
        end else begin
          hi_lo_write = 1'b0;
        end
      end
      ST_HALTED: commit_s = 1'b0;
      default:   commit_s = 1'b0;
    endcase
    pc_write_enable  = commit_s;
    reg_write_enable = commit_s & wr_s;
    // A branch sitting in a delay slot does not re-arm the slot
    target_latch     = commit_s & take_s & ~delay_pending_r;
    pc_sel           = (commit_s & delay_pending_r) ? 2'b01 : 2'b00;
    halt_s           = commit_s & delay_pending_r & target_is_zero;
  end

  // Sequencer state; a commit in any state returns to FETCH or halts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_FETCH;
      ir_r            <= 32'h0000_0000;
      delay_pending_r <= 1'b0;
      cnt_r           <= CNT_ZERO;
    end else if (clk_enable) begin
      case (state_r)
        ST_FETCH: begin
          if (!instr_waitrequest) begin
            ir_r    <= instr_readdata;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cls_muldiv_s) begin
            cnt_r   <= cls_div_s ? DIV_LOAD : MULT_LOAD;
            state_r <= ST_MULDIV;
          end else if (cls_load_s | cls_store_s) begin
            state_r <= ST_MEM;
          end
        end
        ST_MEM: state_r <= ST_MEM;
        ST_MULDIV: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_FETCH;
      endcase
      if (commit_s) begin
        state_r         <= halt_s ? ST_HALTED : ST_FETCH;
        delay_pending_r <= ~delay_pending_r & take_s;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Self-checking bench for mips_cpu_control_fsm: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_mips_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic [31:0] instr_readdata = 32'h0;
  logic        instr_waitrequest = 1'b0;
  logic        data_waitrequest = 1'b0;
  logic [1:0]  addr_low = 2'b00;
  logic        is_true = 1'b0;
  logic        target_is_zero = 1'b0;
  logic        active, instr_read, data_read, data_write;
  logic [3:0]  byte_enable;
  logic [31:0] ir;
  logic        pc_write_enable, target_latch, reg_write_enable, muldiv_start, hi_lo_write;
  logic [1:0]  pc_sel;

  int n_checks = 0;
  int n_fail   = 0;
  bit md_pending = 1'b0;
  bit md_halted  = 1'b0;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 33;
  localparam int K_ALU = 0, K_NOWR = 1, K_JUMP = 2, K_BRANCH = 3;
  localparam int K_LOAD = 4, K_STORE = 5, K_MULT = 6, K_DIV = 7;
  localparam int I_ADDIU = 0, I_ADDU = 3, I_DIV = 7, I_JR = 10, I_BEQ = 12;
  localparam int I_LW = 18, I_SB = 20, I_LH = 23, I_NOP = 24, I_LAST = 24;
  // {active, instr_read, data_read, data_write, byte_enable, pc_write_enable,
  //  pc_sel, target_latch, reg_write_enable, muldiv_start, hi_lo_write}
  localparam logic [14:0] V_RESET  = 15'h4780;
  localparam logic [14:0] V_FETCH  = 15'h6780;
  localparam logic [14:0] V_HALTED = 15'h0780;

  logic [14:0] obs_v;
  assign obs_v = {active, instr_read, data_read, data_write, byte_enable, pc_write_enable,
                  pc_sel, target_latch, reg_write_enable, muldiv_start, hi_lo_write};

  mips_cpu_control_fsm dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
    .data_waitrequest(data_waitrequest), .addr_low(addr_low), .is_true(is_true),
    .target_is_zero(target_is_zero), .active(active), .instr_read(instr_read),
    .data_read(data_read), .data_write(data_write), .byte_enable(byte_enable), .ir(ir),
    .pc_write_enable(pc_write_enable), .pc_sel(pc_sel), .target_latch(target_latch),
    .reg_write_enable(reg_write_enable), .muldiv_start(muldiv_start), .hi_lo_write(hi_lo_write)
  );

  always #5 clk = ~clk;

  // Mnemonic table: instruction word plus its architectural class.
  task automatic pick(input int idx, output logic [31:0] w, output int kind,
                      output int size, output int link);
    logic [31:0] r;
    r = $urandom;
    kind = K_ALU; size = 4; link = 0;
    case (idx)
      0:  w = {6'h09, r[25:0]};                                    // ADDIU
      1:  w = {6'h0d, r[25:0]};                                    // ORI
      2:  w = {6'h3f, r[25:0]};                                    // unknown opcode
      3:  w = {6'h00, r[25:6], 6'h21};                             // ADDU
      4:  w = {6'h00, r[25:6], 6'h2a};                             // SLT
      5:  begin w = {6'h00, r[25:6], 6'h11}; kind = K_NOWR; end    // MTHI
      6:  begin w = {6'h00, r[25:6], 6'h19}; kind = K_MULT; end    // MULTU
      7:  begin w = {6'h00, r[25:6], 6'h1a}; kind = K_DIV; end     // DIV
      8:  begin w = {6'h02, r[25:0]}; kind = K_JUMP; end           // J
      9:  begin w = {6'h03, r[25:0]}; kind = K_JUMP; link = 1; end // JAL
      10: begin w = {6'h00, r[25:6], 6'h08}; kind = K_JUMP; end    // JR
      11: begin w = {6'h00, r[25:6], 6'h09}; kind = K_JUMP; link = 1; end // JALR
      12: begin w = {6'h04, r[25:0]}; kind = K_BRANCH; end         // BEQ
      13: begin w = {6'h07, r[25:0]}; kind = K_BRANCH; end         // BGTZ
      14: begin w = {6'h01, r[25:21], 5'd0, r[15:0]}; kind = K_BRANCH; end           // BLTZ
      15: begin w = {6'h01, r[25:21], 5'd17, r[15:0]}; kind = K_BRANCH; link = 2; end // BGEZAL
      16: begin w = {6'h20, r[25:0]}; kind = K_LOAD; size = 1; end  // LB
      17: begin w = {6'h25, r[25:0]}; kind = K_LOAD; size = 2; end  // LHU
      18: begin w = {6'h23, r[25:0]}; kind = K_LOAD; end            // LW
      19: begin w = {6'h22, r[25:0]}; kind = K_LOAD; end            // LWL
      20: begin w = {6'h28, r[25:0]}; kind = K_STORE; size = 1; end // SB
      21: begin w = {6'h29, r[25:0]}; kind = K_STORE; size = 2; end // SH
      22: begin w = {6'h2b, r[25:0]}; kind = K_STORE; end           // SW
      23: begin w = {6'h21, r[25:0]}; kind = K_LOAD; size = 2; end  // LH
      default: w = 32'h0000_0000;                                  // NOP (SLL)
    endcase
  endtask

  // Drive one instruction from fetch to commit, checking every cycle.
  task automatic run_instr(input string name, input int idx, input int fw, input int dw,
                           input logic tru, input logic [1:0] al, input logic tz);
    logic [31:0] w;
    int kind, size, link, n_post, total, k;
    logic take, wr, commit, e_ir, e_dr, e_dw, e_pcwe, e_tl, e_rwe, e_ms, e_hl;
    logic [1:0] e_pcsel;
    logic [3:0] e_be;
    logic [14:0] e;
    pick(idx, w, kind, size, link);
    take = (kind == K_JUMP) || (kind == K_BRANCH && tru);
    wr = (kind == K_ALU) || (kind == K_LOAD) ||
         ((kind == K_JUMP || kind == K_BRANCH) && (link == 1 || (link == 2 && tru)));
    n_post = (kind == K_LOAD || kind == K_STORE) ? dw + 1 :
             (kind == K_MULT) ? MULT_N : (kind == K_DIV) ? DIV_N : 0;
    total = fw + 2 + n_post;
    is_true = tru; addr_low = al; target_is_zero = tz;
    for (int c = 0; c < total; c++) begin
      instr_waitrequest = (c < fw);
      instr_readdata = (c == fw) ? w : $urandom;
      data_waitrequest = 1'b0;
      commit = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_dw = 1'b0; e_be = 4'b1111;
      e_pcwe = 1'b0; e_pcsel = 2'b00; e_tl = 1'b0; e_rwe = 1'b0; e_ms = 1'b0; e_hl = 1'b0;
      if (c <= fw) begin
        e_ir = 1'b1;
      end else if (c == fw + 1) begin
        if (kind == K_MULT || kind == K_DIV) e_ms = 1'b1;
        else if (kind != K_LOAD && kind != K_STORE) commit = 1'b1;
      end else begin
        k = c - fw - 1;
        if (kind == K_LOAD || kind == K_STORE) begin
          data_waitrequest = (k <= dw);
          e_dr = (kind == K_LOAD);
          e_dw = (kind == K_STORE);
          e_be = (size == 1) ? (4'b0001 << al) :
                 (size == 2) ? (4'b0011 << (al & 2'b10)) : 4'b1111;
          if (k == dw + 1) commit = 1'b1;
        end else if (k == n_post) begin
          commit = 1'b1;
          e_hl = 1'b1;
        end
      end
      if (commit) begin
        e_pcwe = 1'b1;
        e_pcsel = md_pending ? 2'b01 : 2'b00;
        e_tl = take && !md_pending;
        e_rwe = wr;
      end
      e = {1'b1, e_ir, e_dr, e_dw, e_be, e_pcwe, e_pcsel, e_tl, e_rwe, e_ms, e_hl};
      #1;
      n_checks++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d instr %08h: outputs %04h, expected %04h", name, c, w, obs_v, e);
      end
      if (c == fw + 1) begin
        n_checks++;
        if (ir !== w) begin
          n_fail++;
          $display("FAIL %s ir: got %08h, expected %08h", name, ir, w);
        end
      end
      @(negedge clk);
    end
    data_waitrequest = 1'b0;
    md_halted = md_pending && tz;
    md_pending = md_pending ? 1'b0 : take;
    if (md_halted) begin
      for (int h = 0; h < 2; h++) begin
        instr_waitrequest = 1'b0;
        #1;
        n_checks++;
        if (obs_v !== V_HALTED) begin
          n_fail++;
          $display("FAIL %s halted: outputs %04h, expected %04h", name, obs_v, V_HALTED);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; clk_enable = 1'b1;
    instr_waitrequest = 1'b0; data_waitrequest = 1'b0;
    #1;
    n_checks++;
    if (obs_v !== V_RESET || ir !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: outputs %04h ir %08h, expected %04h ir 0", obs_v, ir, V_RESET);
    end
    @(negedge clk);
    reset = 1'b1;
    md_pending = 1'b0;
    md_halted = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    do_reset();
    instr_waitrequest = 1'b1;
    #1;
    n_checks++;
    if (obs_v !== V_FETCH) begin
      n_fail++;
      $display("FAIL reset_fetch: outputs %04h, expected %04h", obs_v, V_FETCH);
    end
    @(negedge clk);
    instr_waitrequest = 1'b0;
  endtask

  task automatic test_alu_and_mem();
    run_instr("addiu", I_ADDIU, 0, 0, 1'b0, 2'b00, 1'b0);
    run_instr("addu_fetch_wait", I_ADDU, 2, 0, 1'b1, 2'b01, 1'b0);
    run_instr("lw_wait3", I_LW, 0, 3, 1'b0, 2'b00, 1'b0);
    run_instr("sb_addr2", I_SB, 0, 0, 1'b0, 2'b10, 1'b0);
    run_instr("lh_addr2", I_LH, 1, 1, 1'b0, 2'b10, 1'b0);
    run_instr("div", I_DIV, 0, 0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", I_BEQ, 0, 0, 1'b1, 2'b00, 1'b0);
    run_instr("addu_delay", I_ADDU, 0, 0, 1'b0, 2'b00, 1'b0);
    run_instr("beq_not_taken", I_BEQ, 0, 0, 1'b0, 2'b00, 1'b0);
    run_instr("addu_after_nt", I_ADDU, 0, 0, 1'b0, 2'b00, 1'b0);
    run_instr("jr", I_JR, 0, 0, 1'b0, 2'b00, 1'b0);
    run_instr("beq_in_slot", I_BEQ, 0, 0, 1'b1, 2'b00, 1'b0);
    run_instr("addu_after_slot", I_ADDU, 0, 0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_halt();
    run_instr("jr_zero", I_JR, 0, 0, 1'b0, 2'b00, 1'b1);
    run_instr("nop_slot", I_NOP, 0, 0, 1'b0, 2'b00, 1'b1);
    do_reset();
  endtask

  task automatic test_reset_muldiv();
    logic [31:0] w;
    int kind, size, link;
    pick(I_DIV, w, kind, size, link);
    instr_readdata = w;
    for (int c = 0; c < 7; c++) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs_v !== V_RESET || ir !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_muldiv: outputs %04h ir %08h, expected %04h ir 0", obs_v, ir, V_RESET);
    end
    @(negedge clk);
    reset = 1'b1;
    md_pending = 1'b0;
    md_halted = 1'b0;
    run_instr("addiu_after_reset", I_ADDIU, 0, 0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_clk_enable();
    logic [31:0] w;
    int kind, size, link;
    pick(I_LW, w, kind, size, link);
    clk_enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      instr_readdata = $urandom;
      #1;
      n_checks++;
      if (obs_v !== V_RESET) begin
        n_fail++;
        $display("FAIL freeze_fetch: outputs %04h, expected %04h", obs_v, V_RESET);
      end
      @(negedge clk);
    end
    clk_enable = 1'b1;
    instr_readdata = w;
    @(negedge clk);
    @(negedge clk);
    data_waitrequest = 1'b1;
    #1;
    n_checks++;
    if (obs_v !== 15'h5780) begin
      n_fail++;
      $display("FAIL mem_before_freeze: outputs %04h, expected %04h", obs_v, 15'h5780);
    end
    @(negedge clk);
    clk_enable = 1'b0;
    data_waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (obs_v !== V_RESET) begin
        n_fail++;
        $display("FAIL freeze_mem: outputs %04h, expected %04h", obs_v, V_RESET);
      end
      @(negedge clk);
    end
    clk_enable = 1'b1;
    #1;
    n_checks++;
    if (obs_v !== 15'h57c4 || ir !== w) begin
      n_fail++;
      $display("FAIL resume_commit: outputs %04h ir %08h, expected %04h ir %08h", obs_v, ir, 15'h57c4, w);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int idx;
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, I_LAST);
      run_instr("random", idx, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0));
      if (md_halted) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu_and_mem();
    test_branch();
    test_halt();
    test_reset_muldiv();
    test_clk_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
